runtime_stats_bank: RTL

Parametrised runtime-statistics unit for the CPU datapath: NUM_EVT independent event counters of CNT_WIDTH bits with halt-aware freezing, synchronous clear, atomic snapshot, saturate-or-wrap overflow handling and a registered read port for the segment-display mux. It replaces the fixed three-counter statistics block (unconditional jumps, conditional branches, taken branches). The datapath drives it with per-instruction event strobes and the halt signal. Software-visible counts are read by index.

---
 rtl/runtime_stats_pkg.sv | 16 +
 rtl/stat_counter.sv | 33 +++
 rtl/runtime_stats_bank.sv | 91 +++++++++
 3 files changed

// File: rtl/runtime_stats_pkg.sv
// Shared types and event indices for the runtime statistics bank.
// No logic: types and constants only, so no latency or backpressure.
package runtime_stats_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  localparam int EVT_CYCLE  = 0;
  localparam int EVT_UNCOND = 1;
  localparam int EVT_COND   = 2;
  localparam int EVT_TAKEN  = 3;

endpackage

// File: rtl/stat_counter.sv
// Single event counter with sync clear and a sticky overflow flag.
// 1-cycle update latency; no backpressure (increment sampled every edge).
module stat_counter #(
  parameter int CNT_WIDTH = 16,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 ovf
);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (&cnt) begin
        ovf <= 1'b1;
        // Saturating mode simply keeps the all-ones value.
        if (SATURATE == 0) cnt <= '0;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/runtime_stats_bank.sv
// Bank of halt-aware event counters with shadow snapshot and registered read port.
// Counters update 1 cycle after the tick, rd_data 1 cycle after rd_sel; no backpressure.
module runtime_stats_bank #(
  parameter int CNT_WIDTH = 16,
  parameter int NUM_EVT   = 8,
  parameter int SATURATE  = 1,
  parameter int SEL_WIDTH = $clog2(NUM_EVT)
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 tick_en,
  input  logic                 halt,
  input  logic [NUM_EVT-1:0]   evt,
  input  logic                 clr,
  input  logic                 snap,
  input  logic                 rd_src,
  input  logic [SEL_WIDTH-1:0] rd_sel,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic [NUM_EVT-1:0]   ovf,
  output logic                 running
);

  import runtime_stats_pkg::*;

  state_t state_q, state_d;

  logic                 count_en;
  logic [CNT_WIDTH-1:0] live   [NUM_EVT];
  logic [CNT_WIDTH-1:0] shadow [NUM_EVT];
  logic [CNT_WIDTH-1:0] rd_next;

  // Every non-halted tick counts: from IDLE/FROZEN it is also the tick that enters RUN.
  assign count_en = tick_en & ~halt;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick_en && !halt) state_d = RUN;
      RUN:     if (tick_en &&  halt) state_d = FROZEN;
      FROZEN:  if (tick_en && !halt) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    running = (state_q == RUN);
  end

  for (genvar i = 0; i < NUM_EVT; i++) begin : g_cnt
    stat_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_cnt (
      .clk (clk),
      .RST (RST),
      .clr (clr),
      .inc (count_en & evt[i]),
      .cnt (live[i]),
      .ovf (ovf[i])
    );
  end

  // Snapshot takes the registered (pre-increment) live values.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_EVT; i++) shadow[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_EVT; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_EVT; i++) shadow[i] <= live[i];
    end
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (int'(rd_sel) == i) rd_next = rd_src ? shadow[i] : live[i];
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) rd_data <= '0;
    else      rd_data <= rd_next;
  end

endmodule
